// File: rtl/hwt_pkg.sv
// Shared types and constants for the hwt trigger counter slice.
package hwt_pkg;

    // Trigger counter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        FIRE    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam int unsigned FIRES_W   = 8;
    localparam int unsigned FIRES_MAX = 255;

    // Ceiling log2; clog2(1) is 0, so callers clamp widths to at least 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hwt_trigger_ctr_if.sv
// Detector-side inputs and trigger-side outputs of hwt_trigger_ctr.
interface hwt_trigger_ctr_if #(
    parameter int unsigned CNT_W = 4
) ();
    import hwt_pkg::*;

    logic               hit;
    logic               clr;
    logic               ack;
    logic               trig;
    logic               busy;
    logic [CNT_W-1:0]   count;
    logic [FIRES_W-1:0] fires;

    // Driver of hit/clr/ack, consumer of the trigger status.
    modport master (
        output hit, clr, ack,
        input  trig, busy, count, fires
    );

    // The trigger counter itself.
    modport slave (
        input  hit, clr, ack,
        output trig, busy, count, fires
    );
endinterface

// File: rtl/hwt_edge_det.sv
// Rising-edge detector on the hwt detector output.
// Build option HWT_TRIG_SYNC_EN inserts a 2-flop synchronizer ahead of hit_d
// so the detector inputs may come from an asynchronous domain.
module hwt_edge_det
    import hwt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic hit,
    output logic rise_c
);

    logic sample;
    logic hit_d;
    logic hit_p;

`ifdef HWT_TRIG_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-stage synchronizer for an asynchronously generated hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= hit;
            sync_2 <= sync_1;
        end
    end

    assign sample = sync_2;
`else
    assign sample = hit;
`endif

    // Input register and previous-sample register; both keep tracking in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_d <= 1'b0;
            hit_p <= 1'b0;
        end else begin
            hit_d <= sample;
            hit_p <= hit_d;
        end
    end

    assign rise_c = hit_d & ~hit_p;

endmodule

// File: rtl/hwt_trigger_ctr.sv
// Counts rising edges of hit inside a sliding inactivity window and raises
// trig after THRESHOLD edges; trig holds until ack, then a hold-off period runs.
// Build option HWT_TRIG_SYNC_EN (in hwt_edge_det) adds a 2-flop input synchronizer.
module hwt_trigger_ctr #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned THRESHOLD = 4,
    parameter int unsigned WINDOW    = 16,
    parameter int unsigned HOLDOFF   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    hwt_trigger_ctr_if.slave bus
);
    // The HOLDOFF parameter shares its name with a state, so states are package-qualified here.

    localparam int unsigned FIRES_W  = hwt_pkg::FIRES_W;
    localparam int unsigned TIMER_W  = hwt_pkg::clog2(WINDOW + 1);
    localparam int unsigned HOLD_RAW = hwt_pkg::clog2(HOLDOFF + 1);
    localparam int unsigned HOLD_W   = (HOLD_RAW == 0) ? 1 : HOLD_RAW;

    localparam logic [CNT_W-1:0]   THR_C     = CNT_W'(THRESHOLD);
    localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
    localparam logic [FIRES_W-1:0] FIRES_TOP = FIRES_W'(hwt_pkg::FIRES_MAX);

    hwt_pkg::state_t      state;
    hwt_pkg::state_t      state_nxt;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_nxt;
    logic [CNT_W-1:0]     count_inc;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_nxt;
    logic [HOLD_W-1:0]    hold_q;
    logic [HOLD_W-1:0]    hold_nxt;
    logic                 trig_q;
    logic                 trig_nxt;
    logic [FIRES_W-1:0]   fires_q;
    logic [FIRES_W-1:0]   fires_nxt;
    logic                 rise;

    hwt_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .hit    (bus.hit),
        .rise_c (rise)
    );

    // count stays below THRESHOLD outside FIRE, so the increment cannot wrap.
    assign count_inc = count_q + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= hwt_pkg::IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clr overrides every transition.
    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = hwt_pkg::IDLE;
        end else begin
            case (state)
                hwt_pkg::IDLE: begin
                    if (rise) begin
                        state_nxt = (THRESHOLD == 1) ? hwt_pkg::FIRE : hwt_pkg::COUNT;
                    end
                end
                hwt_pkg::COUNT: begin
                    // A rise on the timeout cycle wins over the timeout.
                    if (rise) begin
                        if (count_inc == THR_C) begin
                            state_nxt = hwt_pkg::FIRE;
                        end
                    end else if (timer_q == WIN_LAST) begin
                        state_nxt = hwt_pkg::IDLE;
                    end
                end
                hwt_pkg::FIRE: begin
                    if (bus.ack) begin
                        state_nxt = (HOLDOFF == 0) ? hwt_pkg::IDLE : hwt_pkg::HOLDOFF;
                    end
                end
                hwt_pkg::HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_nxt = hwt_pkg::IDLE;
                    end
                end
                default: state_nxt = hwt_pkg::IDLE;
            endcase
        end
    end

    // Next values of count, timers, trig and fires for the current state.
    always_comb begin
        count_nxt = count_q;
        timer_nxt = timer_q;
        hold_nxt  = hold_q;
        trig_nxt  = 1'b0;
        fires_nxt = fires_q;
        if (bus.clr) begin
            count_nxt = '0;
            timer_nxt = '0;
            hold_nxt  = '0;
        end else begin
            case (state)
                hwt_pkg::IDLE: begin
                    if (rise) begin
                        count_nxt = CNT_W'(1);
                        timer_nxt = '0;
                    end
                end
                hwt_pkg::COUNT: begin
                    if (rise) begin
                        count_nxt = count_inc;
                        timer_nxt = '0;
                    end else if (timer_q == WIN_LAST) begin
                        count_nxt = '0;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer_q + TIMER_W'(1);
                    end
                end
                hwt_pkg::FIRE: begin
                    // trig rises the cycle after FIRE entry and drops the cycle after ack.
                    trig_nxt = ~bus.ack;
                    if (bus.ack) begin
                        count_nxt = '0;
                        hold_nxt  = HOLD_LOAD;
                        if (fires_q != FIRES_TOP) begin
                            fires_nxt = fires_q + FIRES_W'(1);
                        end
                    end
                end
                hwt_pkg::HOLDOFF: begin
                    if (hold_q != '0) begin
                        hold_nxt = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    count_nxt = '0;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            timer_q <= '0;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            fires_q <= '0;
        end else begin
            count_q <= count_nxt;
            timer_q <= timer_nxt;
            hold_q  <= hold_nxt;
            trig_q  <= trig_nxt;
            fires_q <= fires_nxt;
        end
    end

    assign bus.trig  = trig_q;
    assign bus.busy  = (state != hwt_pkg::IDLE);
    assign bus.count = count_q;
    assign bus.fires = fires_q;

endmodule

// File: tb/tb_hwt_trigger_ctr.sv
// Scoreboard bench for hwt_trigger_ctr: directed scenarios plus random traffic,
// checked against an event-time reference model.
module tb_hwt_trigger_ctr;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned THRESHOLD = 4;
    localparam int unsigned WINDOW    = 16;
    localparam int unsigned HOLDOFF   = 8;
`ifdef HWT_TRIG_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hwt_trigger_ctr_if #(.CNT_W(CNT_W)) bus_if ();

    hwt_trigger_ctr #(
        .CNT_W     (CNT_W),
        .THRESHOLD (THRESHOLD),
        .WINDOW    (WINDOW),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int trig;
        int busy;
        int count;
        int fires;
    } exp_t;

    typedef enum int {M_IDLE, M_COUNT, M_FIRE, M_HOLD} mmode_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;

    // Reference model: edges counted, cycle stamps of last edge and hold-off end.
    mmode_t mode;
    int     edges;
    int     fires;
    int     trig_m;
    int     cyc;
    int     last_edge;
    int     hold_end;
    bit     hist [0:LAT];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mode      = M_IDLE;
        edges     = 0;
        fires     = 0;
        trig_m    = 0;
        cyc       = 0;
        last_edge = 0;
        hold_end  = 0;
        for (int i = 0; i <= LAT; i++) hist[i] = 1'b0;
    endtask

    // Applies one clock edge with the given sampled inputs to the model.
    task automatic model_edge(input bit h, input bit c, input bit a);
        bit rise;
        bit was_fire;
        rise = hist[LAT-1] && !hist[LAT];
        for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = h;
        cyc++;
        was_fire = (mode == M_FIRE);
        if (c) begin
            mode   = M_IDLE;
            edges  = 0;
            trig_m = 0;
        end else begin
            trig_m = (was_fire && !a) ? 1 : 0;
            case (mode)
                M_IDLE: if (rise) begin
                    edges     = 1;
                    last_edge = cyc;
                    mode      = (THRESHOLD == 1) ? M_FIRE : M_COUNT;
                end
                M_COUNT: begin
                    if (rise) begin
                        edges++;
                        last_edge = cyc;
                        if (edges == int'(THRESHOLD)) mode = M_FIRE;
                    end else if (cyc - last_edge >= int'(WINDOW)) begin
                        mode  = M_IDLE;
                        edges = 0;
                    end
                end
                M_FIRE: if (a) begin
                    fires = (fires < 255) ? fires + 1 : 255;
                    edges = 0;
                    if (HOLDOFF == 0) mode = M_IDLE;
                    else begin
                        mode     = M_HOLD;
                        hold_end = cyc + int'(HOLDOFF);
                    end
                end
                M_HOLD: if (cyc >= hold_end) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, queue them.
    task automatic step(input bit h, input bit c, input bit a);
        exp_t e;
        bus_if.hit = h;
        bus_if.clr = c;
        bus_if.ack = a;
        @(posedge clk);
        model_edge(h, c, a);
        e.trig  = trig_m;
        e.busy  = (mode != M_IDLE) ? 1 : 0;
        e.count = edges;
        e.fires = fires;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input int lows);
        step(1'b1, 1'b0, 1'b0);
        idle(lows);
    endtask

    task automatic fire_now();
        repeat (THRESHOLD) pulse(1);
        idle(LAT + 2);
    endtask

    // Assert reset between edges and check outputs drop without a clock edge.
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_trig"},  int'(bus_if.trig),  0);
        check({tag, "_busy"},  int'(bus_if.busy),  0);
        check({tag, "_count"}, int'(bus_if.count), 0);
        check({tag, "_fires"}, int'(bus_if.fires), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued prediction.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("trig",  int'(bus_if.trig),  mon_e.trig);
            check("busy",  int'(bus_if.busy),  mon_e.busy);
            check("count", int'(bus_if.count), mon_e.count);
            check("fires", int'(bus_if.fires), mon_e.fires);
        end
    end

    initial begin
        bus_if.hit = 1'b0;
        bus_if.clr = 1'b0;
        bus_if.ack = 1'b0;
        model_reset();
        #12;
        check("rst_trig",  int'(bus_if.trig),  0);
        check("rst_busy",  int'(bus_if.busy),  0);
        check("rst_count", int'(bus_if.count), 0);
        check("rst_fires", int'(bus_if.fires), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic fire, ack, hold-off.
        repeat (4) pulse(3);
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        idle(12);

        // Timeout after two edges.
        pulse(3);
        pulse(3);
        idle(20);

        // Rise exactly on the last window cycle, then one cycle too late.
        pulse(3);
        pulse(15);
        pulse(3);
        pulse(3);
        idle(3);
        step(1'b0, 1'b0, 1'b1);
        idle(10);
        pulse(3);
        pulse(16);
        idle(20);

        // Held level counts once; pulses in FIRE and HOLDOFF are ignored.
        repeat (50) step(1'b1, 1'b0, 1'b0);
        idle(3);
        fire_now();
        repeat (3) pulse(1);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) pulse(1);
        idle(10);
        fire_now();
        step(1'b1, 1'b0, 1'b1);
        repeat (15) step(1'b1, 1'b0, 1'b0);
        idle(20);

        // Ack outside FIRE, clr in COUNT and in FIRE.
        step(1'b0, 1'b0, 1'b1);
        repeat (3) pulse(2);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        fire_now();
        step(1'b0, 1'b1, 1'b0);
        idle(5);

        // Saturation of the fire counter.
        for (int n = 0; n < 260; n++) begin
            fire_now();
            step(1'b0, 1'b0, 1'b1);
            idle(HOLDOFF + 1);
        end
        @(negedge clk);
        #1;
        check("fires_sat", int'(bus_if.fires), 255);

        // Reset in the middle of FIRE.
        fire_now();
        check("pre_rst_trig", int'(bus_if.trig), 1);
        async_reset_check("midfire");

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 999) < 8),
                 ($urandom_range(0, 99) < 15));
        end
        idle(3);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwt_trigger_ctr.md
Name: hwt_trigger_ctr

Overview:
Sequential stage directly downstream of the combinational hwt detector. It consumes the detector's single-bit output Y, where Y = D & (C ^ (A & B)), as input hit. It counts rising edges of hit inside a sliding inactivity window. When THRESHOLD edges accumulate, it raises trig and holds it until the consumer acknowledges, then enters a hold-off period before re-arming.

Parameters:
CNT_W, 4, width of edge counter; legal THRESHOLD range 1..2^CNT_W-1
THRESHOLD, 4, rising edges required to fire
WINDOW, 16, max cycles allowed between consecutive edges in COUNT (>=1)
HOLDOFF, 8, cycles spent in HOLDOFF after ack (0 = return straight to IDLE)

Ports:
clk  input  1  single clock, all flops rising-edge
rst_n  input  1  asynchronous, active-low reset
hit  input  1  detector output Y from hwt
clr  input  1  synchronous clear, active-high
ack  input  1  consumer acknowledge of trig
trig  output  1  trigger, level, held until ack
busy  output  1  high whenever state != IDLE
count  output  CNT_W  current edge count
fires  output  8  number of completed fires, saturates at 255

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, trig=0, busy=0, count=0, fires=0, timer=0, hit pipeline=0.
- Input register hit_d <= hit. Previous-sample register hit_p <= hit_d. rise = hit_d & ~hit_p (combinational).
- Latency: hit sampled high at edge k -> count updates at edge k+1.
- IDLE: on rise, count<=1 and timer<=0. Next state is COUNT, or FIRE if THRESHOLD==1.
- COUNT: timer increments every cycle without a rise.
  - On rise: count<=count+1 and timer<=0. If count+1==THRESHOLD, next state is FIRE.
  - No rise and timer==WINDOW-1: state<=IDLE, count<=0 (timeout).
  - A rise on the timeout cycle wins: the count increments and the timeout is discarded.
- FIRE: trig=1 (registered, asserted the cycle after entry edge); count held at THRESHOLD; rises ignored.
  - On ack: next cycle trig=0, count=0, fires<=sat(fires+1). State goes to HOLDOFF with hold counter=HOLDOFF-1, or to IDLE if HOLDOFF==0.
  - An ack arriving outside FIRE is ignored.
- HOLDOFF: rises ignored; hold counter decrements; at 0, state goes to IDLE.
  - hit_p keeps tracking during HOLDOFF, so a level held high across the exit does not count as a new edge.
- clr: highest priority after reset. Next cycle: state=IDLE, count=0, timer=0, trig=0. fires is preserved. Pipeline registers keep sampling.
- Reset asserted mid-operation: immediate return to reset values, including trig drop, with no clock needed.
- busy is combinational from state.
- count never exceeds THRESHOLD.
- timer width = clog2(WINDOW+1); no wrap.

Optional Feature:
HWT_TRIG_SYNC_EN
- Defined: hit passes through a 2-flop synchronizer before hit_d. This allows the detector inputs A..D to come from an asynchronous domain. Edge-to-count latency becomes 3 cycles.
- Undefined: a single input register only, with 1-cycle edge-to-count latency as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package hwt_pkg holds:
  - state enum typedef (IDLE, COUNT, FIRE, HOLDOFF, 2-bit encoding);
  - FIRES_W=8 and FIRES_MAX=255 constants;
  - clog2 helper function.
- One natural sub-module, hwt_edge_det: optional synchronizer plus hit_d/hit_p registers, producing rise. The counter FSM stays in hwt_trigger_ctr.

Test Plan:
1. Reset then 4 hit pulses (1 high, 3 low each): count steps 1,2,3; trig=1 two cycles after the 4th pulse is sampled. Then ack=1 for 1 cycle: trig=0 next cycle, fires=1, busy high for 8 more cycles, then IDLE.
2. 2 pulses, then hit low for 16 cycles: state returns to IDLE and count=0 exactly 16 cycles after the 2nd count update; trig never asserts.
3. Rise landing on timer==15 cycle: count increments to 3, no timeout; 4th pulse then fires.
4. hit held high for 50 cycles from IDLE: count=1 only. Pulses during FIRE and HOLDOFF: count unchanged, no second fire.
5. clr during COUNT (count=3) and during FIRE: next cycle count=0, trig=0, IDLE, fires unchanged. rst_n low mid-FIRE: trig=0 asynchronously, fires=0.
6. 260 fire/ack cycles: fires saturates at 255. With HWT_TRIG_SYNC_EN: count update 3 cycles after hit rises.
